// File: rtl/spi_master.sv
// Mode-0 SPI master: one m-bit word per SS-low frame, MSB first, full duplex.
// SCLK phases are timed by a divide counter so every phase lasts exactly CLKDIV GCLK cycles.
module spi_master #(
  parameter int m      = 15,
  parameter int CLKDIV = 4
) (
  input  logic         GCLK,
  input  logic         RST,
  input  logic         START,
  input  logic [m-1:0] DIN,
  output logic         BUSY,
  output logic         DONE,
  output logic [m-1:0] DOUT,
  output logic         SS,
  output logic         SCLK,
  output logic         MOSI,
  input  logic         MISO
);

  localparam int DW = $clog2(CLKDIV) + 1;
  localparam int BW = $clog2(m) + 1;

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;

  state_t         state, state_nx;
  logic [DW-1:0]  div_cnt;
  logic [BW-1:0]  bit_cnt;
  logic [m-1:0]   tx_sr;
  logic [m-1:0]   rx_sr;
  logic           phase_end;
  logic           last_bit;

  assign phase_end = (div_cnt == DW'(CLKDIV - 1));
  // bit_cnt is already advanced when LOW is reached, so m means all bits are in
  assign last_bit  = (bit_cnt == BW'(m));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (START)     state_nx = SETUP;
      SETUP:   if (phase_end) state_nx = HIGH;
      HIGH:    if (phase_end) state_nx = LOW;
      LOW:     if (phase_end) state_nx = last_bit ? GAP : HIGH;
      GAP:     if (phase_end) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge GCLK) begin
    if (!RST) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      DOUT    <= '0;
      SS      <= 1'b1;
      SCLK    <= 1'b0;
      MOSI    <= 1'b0;
    end else begin
      state   <= state_nx;
      DONE    <= 1'b0;
      SCLK    <= (state_nx == HIGH);
      div_cnt <= (state_nx != state || state == IDLE) ? '0 : div_cnt + DW'(1);
      case (state)
        IDLE: begin
          if (START) begin
            tx_sr   <= DIN;
            rx_sr   <= '0;
            bit_cnt <= '0;
            SS      <= 1'b0;
            MOSI    <= DIN[m-1];
            BUSY    <= 1'b1;
          end
        end
        HIGH: begin
          if (phase_end) begin
            rx_sr   <= {rx_sr[m-2:0], MISO};
            bit_cnt <= bit_cnt + BW'(1);
            // rotate rather than shift so the word stays intact; only bit m-2 is presented next
            if (bit_cnt != BW'(m - 1)) begin
              tx_sr <= {tx_sr[m-2:0], tx_sr[m-1]};
              MOSI  <= tx_sr[m-2];
            end
          end
        end
        LOW: begin
          if (phase_end && last_bit) begin
            SS   <= 1'b1;
            DONE <= 1'b1;
            DOUT <= rx_sr;
          end
        end
        GAP: begin
          if (phase_end) begin
            BUSY <= 1'b0;
            MOSI <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/spi_master.md
# spi_master

Single-clock SPI master that drives the team's SPI slave link: generates SS, SCLK and MOSI from GCLK, shifts one m-bit word out MSB-first and simultaneously captures m bits from MISO. Sits upstream of the slave in the same clock domain as the host logic. Mode 0 (SCLK idles low; MOSI/MISO change on SCLK falling edges, sampled on rising edges), one word per SS-low frame.

## Interface
Parameters:
- m, 15, word length in bits (≥2).
- CLKDIV, 4, GCLK cycles per SCLK half-period (≥1).

Ports:
- GCLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  reset, synchronous, active-low.
- START  input  1  request one frame; accepted only when BUSY=0.
- DIN  input  m  word to transmit; captured on the accepting edge.
- BUSY  output  1  high from the accepting edge until the frame gap ends.
- DONE  output  1  one-cycle pulse when a frame completes.
- DOUT  output  m  last received word; updated together with DONE.
- SS  output  1  slave select, active-low.
- SCLK  output  1  serial clock.
- MOSI  output  1  serial data out, MSB first.
- MISO  input  1  serial data in from slave.

## Operation
- All outputs registered. Reset (RST=0 at a GCLK edge): state IDLE, SS=1, SCLK=0, MOSI=0, BUSY=0, DONE=0, DOUT=0, counters and shift registers cleared.
- States: IDLE, SETUP, HIGH, LOW, GAP.
- IDLE: START=1 → latch DIN into TX shift register, clear RX register, SS=0, MOSI=DIN[m-1], BUSY=1, bit count=0, → SETUP.
- SETUP: SCLK=0 for CLKDIV cycles (gives slave time to load its TX word and present MISO) → HIGH.
- HIGH: SCLK=1 for CLKDIV cycles. On the edge leaving HIGH, shift MISO into RX LSB (RX <= {RX[m-2:0], MISO}), increment bit count → LOW.
- LOW: SCLK=0 for CLKDIV cycles. On entering LOW, if bits remain, MOSI=next TX bit. On leaving: if bit count < m → HIGH; else (last LOW doubles as SS hold time) → GAP with SS=1, DONE=1, DOUT=RX.
- GAP: SS=1, SCLK=0 for CLKDIV cycles (minimum SS-high time for the slave to latch its word); DONE high only in first GAP cycle; then BUSY=0, → IDLE.
- MOSI after the last bit holds its final value until IDLE; returns to 0 on entering IDLE.
- Divide counter width clog2(CLKDIV)+1; bit counter width clog2(m)+1; no wrap inside a frame.

## Timing
- START sampled at edge 0 with BUSY=0. SS low from cycle 1 through cycle CLKDIV·(2m+1) inclusive.
- k-th SCLK rising edge (k=1..m) at cycle 1+CLKDIV·(2k−1); MISO bit k captured CLKDIV cycles later.
- DONE=1 and DOUT valid at cycle CLKDIV·(2m+1)+1, same cycle SS returns high.
- BUSY=0 at cycle CLKDIV·(2m+2)+1; START may be accepted on that edge. Back-to-back frame period CLKDIV·(2m+2)+1 cycles.
- START while BUSY=1 (including the DONE cycle) ignored, no queueing. DIN changes after acceptance have no effect.
- Reset mid-frame: next edge forces reset values; SS rises immediately, no DONE, DOUT=0. Reset has priority over START in the same cycle.
- SCLK never glitches: each phase lasts exactly CLKDIV cycles; CLKDIV=1 gives SCLK = GCLK/2.

## Test plan
- Reset: hold RST=0 3 cycles with START=1 → SS=1, SCLK=0, BUSY=0, DONE=0, DOUT=0 throughout; no frame starts.
- Single frame, m=15, CLKDIV=2, DIN=15'h5A3C, MISO loopback from MOSI → SS low cycles 1–62, 15 SCLK pulses, DONE at cycle 63, DOUT=15'h5A3C, BUSY low at 65.
- With slave model returning 15'h7FFF then 15'h0001 on consecutive back-to-back frames (START held high) → DOUT=7FFF then 0001; second SS fall exactly at cycle 66, SS high ≥2 cycles between frames.
- START pulsed at cycles 10 and 63 during a frame → ignored; exactly one DONE; DOUT unchanged by ignored requests.
- Reset asserted at cycle 30 mid-frame → SS=1, SCLK=0 at cycle 31, no DONE, DOUT=0; subsequent START runs a clean full frame.
- CLKDIV=1, m=2, DIN=2'b10, MISO=1 constant → SCLK high cycles 2 and 4, MOSI 1 then 0, DONE at cycle 6, DOUT=2'b11.
